// File: rtl/sample_window_pkg.sv
// Types shared by the FIR input stage, the mac block and the coefficient store.
//   sample_t      : one sample or tap value, DATA_WIDTH bits, stored unmodified.
//   windowState_t : fill state of the tap delay line.
package sample_window_pkg;

  `include "constants.svh"

  typedef logic [DATA_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } windowState_t;

endpackage

// File: rtl/constants.svh
// Shared FIR datapath constants.
// Include this file inside a package or module scope. It declares localparams,
// so every scope that needs the values gets its own copy.
//   DATA_WIDTH : width of one sample and of one tap.
//   NUM_REGS   : number of taps in the delay line (must be >= 2).
localparam int DATA_WIDTH = 16;
localparam int NUM_REGS   = 8;

// File: rtl/tap_shift_reg.sv
// Tap delay line with an enable and a synchronous clear.
// On each enabled rising edge, a new value enters at taps[0] and every other tap
// moves one place toward the end of the line. The value in the last tap is dropped.
//   clk     : clock
//   rst     : synchronous active-high reset; all taps go to 0
//   clear   : synchronous clear; all taps go to 0
//   shiftEn : shift dataIn into the line this cycle
//   dataIn  : value that enters taps[0]
//   taps    : parallel tap vector; taps[0] holds the newest value
module tap_shift_reg #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shiftEn,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] taps [0:DEPTH-1]
);

  // Reset and clear share one path because both must leave an all-zero window.
  // When a clear arrives together with a shift, the clear wins.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int k = 0; k < DEPTH; k++) begin
        taps[k] <= '0;
      end
    end else if (shiftEn) begin
      taps[0] <= dataIn;
      for (int k = 1; k < DEPTH; k++) begin
        taps[k] <= taps[k-1];
      end
    end
  end

endmodule

// File: rtl/sample_window.sv
// FIR input stage. Samples arrive over a valid/ready handshake and are shifted
// into a NUM_REGS-deep tap delay line. The stage tracks the fill level and
// flags when a window is ready for the mac block.
//   clk         : clock
//   rst         : synchronous active-high reset
//   sampleIn    : incoming sample
//   sampleValid : sampleIn is valid this cycle
//   sampleReady : the stage can accept a sample this cycle
//   flush       : synchronous clear of the window
//   outReady    : the downstream consumer takes the current window
//   pDataOut    : tap vector; [0] is the newest sample
//   windowValid : pDataOut holds a window to be consumed
//   fillCount   : number of samples held, 0..NUM_REGS
module sample_window
  import sample_window_pkg::*;
#(
  parameter int DATA_WIDTH   = sample_window_pkg::DATA_WIDTH,
  parameter int NUM_REGS     = sample_window_pkg::NUM_REGS,
  parameter bit EMIT_PARTIAL = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         sampleIn,
  input  logic                          sampleValid,
  output logic                          sampleReady,
  input  logic                          flush,
  input  logic                          outReady,
  output logic [DATA_WIDTH-1:0]         pDataOut [0:NUM_REGS-1],
  output logic                          windowValid,
  output logic [$clog2(NUM_REGS+1)-1:0] fillCount
);

  localparam int CountWidth = $clog2(NUM_REGS + 1);
  localparam logic [CountWidth-1:0] FullCount = CountWidth'(NUM_REGS);
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(NUM_REGS - 1);

  windowState_t            stateQ;
  windowState_t            stateD;
  logic [CountWidth-1:0]   fillD;
  logic                    validD;
  logic                    accept;

  // Ready does not depend on sampleValid. This keeps the handshake free of
  // combinational loops. A window that is waiting for the consumer blocks new
  // samples, because a shift would overwrite a window that was never consumed.
  assign sampleReady = !rst && !flush && (!windowValid || outReady);
  assign accept      = sampleValid && sampleReady;

  tap_shift_reg #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (NUM_REGS)
  ) taps (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .shiftEn (accept),
    .dataIn  (sampleIn),
    .taps    (pDataOut)
  );

  // Next-state logic for the fill FSM, the fill counter and windowValid.
  // The state that follows an accept decides whether the new window is complete.
  // That is why the FILLING->FULL step looks at the count before it increments.
  // An accept always replaces the window, so it takes priority over a consume.
  always_comb begin
    stateD = stateQ;
    fillD  = fillCount;
    validD = windowValid;
    if (flush) begin
      stateD = EMPTY;
      fillD  = '0;
      validD = 1'b0;
    end else begin
      if (accept) begin
        if (fillCount != FullCount) begin
          fillD = fillCount + 1'b1;
        end
        unique case (stateQ)
          EMPTY:   stateD = FILLING;
          FILLING: if (fillCount == LastCount) stateD = FULL;
          FULL:    stateD = FULL;
          default: stateD = EMPTY;
        endcase
      end
      if (accept && (stateD == FULL || EMIT_PARTIAL)) begin
        validD = 1'b1;
      end else if (outReady) begin
        validD = 1'b0;
      end
    end
  end

  // State register. Reset takes priority over everything, including a window
  // that is stalled and waiting for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ      <= EMPTY;
      fillCount   <= '0;
      windowValid <= 1'b0;
    end else begin
      stateQ      <= stateD;
      fillCount   <= fillD;
      windowValid <= validD;
    end
  end

endmodule

// File: tb/tb_sample_window.sv
// Self-checking bench for sample_window.
// Two instances share all inputs: dutA has EMIT_PARTIAL = 0 and dutB has
// EMIT_PARTIAL = 1. The reference model keeps the history of accepted samples
// for each instance. It derives the taps, the fill level and windowValid from
// that history.
module tb_sample_window;

  localparam int Dw = 16;
  localparam int Nr = 8;

  logic          clk;
  logic          rst;
  logic [Dw-1:0] sampleIn;
  logic          sampleValid;
  logic          flush;
  logic          outReady;

  logic          readyA, readyB;
  logic          validA, validB;
  logic [Dw-1:0] tapsA [0:Nr-1];
  logic [Dw-1:0] tapsB [0:Nr-1];
  logic [3:0]    fillA, fillB;

  int checks = 0;
  int passes = 0;

  // Model state: the newest samples are at the back of each queue.
  int histA[$];
  int histB[$];
  bit mValidA = 1'b0;
  bit mValidB = 1'b0;

  sample_window #(.DATA_WIDTH(Dw), .NUM_REGS(Nr), .EMIT_PARTIAL(1'b0)) dutA (
    .clk(clk), .rst(rst), .sampleIn(sampleIn), .sampleValid(sampleValid),
    .sampleReady(readyA), .flush(flush), .outReady(outReady),
    .pDataOut(tapsA), .windowValid(validA), .fillCount(fillA)
  );

  sample_window #(.DATA_WIDTH(Dw), .NUM_REGS(Nr), .EMIT_PARTIAL(1'b1)) dutB (
    .clk(clk), .rst(rst), .sampleIn(sampleIn), .sampleValid(sampleValid),
    .sampleReady(readyB), .flush(flush), .outReady(outReady),
    .pDataOut(tapsB), .windowValid(validB), .fillCount(fillB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end else begin
      passes++;
    end
  endtask

  // Tap k of a window built from an accept history; taps not yet filled read as 0.
  function automatic int expTap(input int q[$], input int k);
    if (k < q.size()) return q[q.size() - 1 - k];
    return 0;
  endfunction

  function automatic int sumTaps(input logic [Dw-1:0] t [0:Nr-1]);
    int s = 0;
    for (int k = 0; k < Nr; k++) s += int'(t[k]);
    return s;
  endfunction

  // Drive one cycle of inputs at the falling edge. Then check every output
  // against the model, and step the model to the state after the next rising edge.
  task automatic applyStimulus(input bit r, input bit f, input bit v,
                               input int s, input bit o);
    bit rdyA, rdyB;
    @(negedge clk);
    rst = r; flush = f; sampleValid = v; sampleIn = Dw'(s); outReady = o;
    #1;
    rdyA = !r && !f && (!mValidA || o);
    rdyB = !r && !f && (!mValidB || o);
    checkOutput("readyA", 32'(readyA), 32'(rdyA));
    checkOutput("readyB", 32'(readyB), 32'(rdyB));
    checkOutput("validA", 32'(validA), 32'(mValidA));
    checkOutput("validB", 32'(validB), 32'(mValidB));
    checkOutput("fillA", 32'(fillA), 32'(histA.size()));
    checkOutput("fillB", 32'(fillB), 32'(histB.size()));
    for (int k = 0; k < Nr; k++) begin
      checkOutput($sformatf("tapA%0d", k), 32'(tapsA[k]), 32'(expTap(histA, k)));
      checkOutput($sformatf("tapB%0d", k), 32'(tapsB[k]), 32'(expTap(histB, k)));
    end
    if (r || f) begin
      histA.delete(); histB.delete();
      mValidA = 1'b0; mValidB = 1'b0;
    end else begin
      if (v && rdyA) begin
        histA.push_back(s & 16'hFFFF);
        if (histA.size() > Nr) void'(histA.pop_front());
        if (histA.size() == Nr) mValidA = 1'b1;
        else if (o) mValidA = 1'b0;
      end else if (o) begin
        mValidA = 1'b0;
      end
      if (v && rdyB) begin
        histB.push_back(s & 16'hFFFF);
        if (histB.size() > Nr) void'(histB.pop_front());
        mValidB = 1'b1;
      end else if (o) begin
        mValidB = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; sampleValid = 1'b1; sampleIn = 16'd77; outReady = 1'b1;

    // Reset held for three cycles with a sample on offer.
    repeat (3) applyStimulus(1, 0, 1, 77, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("readyAfterReset", 32'(readyA), 32'd1);
    checkOutput("fillAfterReset", 32'(fillA), 32'd0);

    // Fill with 1..8; the 8th accept raises windowValid on dutA.
    for (int k = 1; k <= Nr; k++) applyStimulus(0, 0, 1, k, 1);
    applyStimulus(0, 0, 1, 9, 1);
    checkOutput("fullValid", 32'(validA), 32'd1);
    checkOutput("fullFill", 32'(fillA), 32'd8);
    checkOutput("mac36", 32'(sumTaps(tapsA)), 32'd36);
    checkOutput("newest8", 32'(tapsA[0]), 32'd8);
    checkOutput("oldest1", 32'(tapsA[Nr-1]), 32'd1);

    // Backpressure: 10 is offered while outReady stays low.
    applyStimulus(0, 0, 1, 10, 0);
    checkOutput("mac44", 32'(sumTaps(tapsA)), 32'd44);
    checkOutput("slideValid", 32'(validA), 32'd1);
    checkOutput("stallReady", 32'(readyA), 32'd0);
    repeat (3) applyStimulus(0, 0, 1, 10, 0);
    checkOutput("frozenTap0", 32'(tapsA[0]), 32'd9);
    checkOutput("frozenFill", 32'(fillA), 32'd8);
    applyStimulus(0, 0, 1, 10, 1);
    checkOutput("releaseReady", 32'(readyA), 32'd1);

    // Flush together with a sample on offer.
    applyStimulus(0, 1, 1, 55, 1);
    checkOutput("tap0Is10", 32'(tapsA[0]), 32'd10);
    checkOutput("flushReady", 32'(readyA), 32'd0);
    applyStimulus(0, 0, 1, 55, 1);
    checkOutput("flushFill", 32'(fillA), 32'd0);
    checkOutput("flushValid", 32'(validA), 32'd0);
    checkOutput("flushTap0", 32'(tapsA[0]), 32'd0);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("reoffer55", 32'(tapsA[0]), 32'd55);
    checkOutput("reofferFill", 32'(fillA), 32'd1);

    // Partial windows on dutB: stream 3 then 5.
    applyStimulus(0, 0, 1, 3, 1);
    applyStimulus(0, 0, 1, 5, 1);
    checkOutput("partialValid1", 32'(validB), 32'd1);
    checkOutput("partialTap0a", 32'(tapsB[0]), 32'd3);
    checkOutput("partialTap1a", 32'(tapsB[1]), 32'd0);
    checkOutput("noPartialA", 32'(validA), 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("partialTap0b", 32'(tapsB[0]), 32'd5);
    checkOutput("partialTap1b", 32'(tapsB[1]), 32'd3);
    checkOutput("partialTap2b", 32'(tapsB[2]), 32'd0);

    // Random traffic with occasional reset, flush and stalls.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(99) < 2, $urandom_range(99) < 5,
                    $urandom_range(99) < 70, int'($urandom_range(65535)),
                    $urandom_range(99) < 60);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sample_window.md
# sample_window

Input stage of the FIR datapath: accepts a stream of samples over a valid/ready handshake and shifts them into a `NUM_REGS`-deep tap delay line. The parallel tap vector drives the `pDataIn` array of the `mac` block directly. The stage also tracks fill level and flags when a complete window is presented. It applies backpressure when the downstream consumer stalls, and it supports a synchronous flush between data blocks.

## Interface
- `DATA_WIDTH`, from `constants.svh`: width of one sample and of one tap.
- `NUM_REGS`, from `constants.svh` (8): number of taps. Must be ≥2.
- `EMIT_PARTIAL`, default 0: when 1, `windowValid` is also raised while filling; unfilled taps read as 0.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sampleIn`  in  `DATA_WIDTH`: incoming sample.
- `sampleValid`  in  1: `sampleIn` is valid this cycle.
- `sampleReady`  out  1: the stage can accept a sample this cycle.
- `flush`  in  1: synchronous clear of the window.
- `outReady`  in  1: the downstream consumer takes the current window.
- `pDataOut`  out  `[0:NUM_REGS-1]` × `DATA_WIDTH`: tap vector; `[0]` is the newest sample.
- `windowValid`  out  1: `pDataOut` holds a window to be consumed.
- `fillCount`  out  `$clog2(NUM_REGS+1)`: number of samples held, 0..`NUM_REGS`.

## Operation
- **Accept event:** `accept = sampleValid && sampleReady`.
- **Ready:** `sampleReady = !rst && !flush && (!windowValid || outReady)`. This is combinational and has no dependency on `sampleValid`.
- **On accept:**
  - `pDataOut[0] <= sampleIn`.
  - `pDataOut[k] <= pDataOut[k-1]` for k = 1..`NUM_REGS-1`.
  - The oldest sample is discarded.
- **fillCount:** increments on accept and saturates at `NUM_REGS`.
- **State machine** (internal, `EMPTY` / `FILLING` / `FULL`):
  - `EMPTY`→`FILLING` on the first accept.
  - `FILLING`→`FULL` on the accept that brings `fillCount` to `NUM_REGS`.
  - `FULL` is held on further accepts.
  - Any state goes to `EMPTY` on `flush` or `rst`.
- **windowValid next-state:**
  - 1 if there is an accept and the next state is `FULL`. With `EMIT_PARTIAL` = 1, any accept also sets it.
  - Otherwise 0 if `outReady`.
  - Otherwise the current value is held.
- **Stall:** while `windowValid && !outReady`, `pDataOut` and `fillCount` are frozen and no sample is accepted.
- **Flush:**
  - Next cycle: all taps are 0, `fillCount` = 0, `windowValid` = 0, state is `EMPTY`.
  - `flush` outranks a concurrent `sampleValid`. No sample is lost, because `sampleReady` is 0 during `flush`.
- **Arithmetic:** samples are stored unmodified, with no sign extension or truncation.

## Timing
- **Reset values:** all taps 0, `fillCount` 0, `windowValid` 0, state `EMPTY`. `sampleReady` is 0 while `rst` is high and 1 on the first cycle after reset.
- **Latency:** a sample accepted at edge N appears on `pDataOut[0]` and updates `windowValid` at edge N (visible in cycle N+1).
- **Throughput:** one sample per cycle when `outReady` is held high. Back-to-back windows are produced every cycle once in `FULL`.
- **Consume + accept in the same cycle:** the window is consumed and replaced by the new shifted window; `windowValid` stays 1.
- **Reset mid-stall:** reset wins; the pending window is dropped.
- **Boundary at saturation:** the `NUM_REGS`-th accept raises `windowValid` even with `EMIT_PARTIAL` = 0. Accepts after that never overflow `fillCount`.

## Structure
- `DATA_WIDTH` and `NUM_REGS` stay in the shared `constants.svh`.
- The state enum and a `sample_t` typedef (`logic [DATA_WIDTH-1:0]`) go in the shared package, for reuse by `mac` and the coefficient store.
- One natural sub-module, `tap_shift_reg`: a parameterised enable/clear shift register holding the taps.
- The FSM, fill counter and handshake logic stay in `sample_window`.

## Test plan
All scenarios use `NUM_REGS` = 8, `DATA_WIDTH` = 16.
- **Reset:** hold `rst` for 3 cycles with `sampleValid` = 1 → no accept; taps all 0, `fillCount` 0, `windowValid` 0; `sampleReady` becomes 1 one cycle after release.
- **Fill:** stream 1..8 with `outReady` = 1 → `windowValid` stays 0 for the first 7 accepts and rises after the 8th. `pDataOut` = {8,7,6,5,4,3,2,1}; `mac` with all coefs 1 gives 36.
- **Sliding window:** continue with 9 → `pDataOut` = {9,8,…,2}, `windowValid` stays 1, MAC sum = 44.
- **Backpressure:** hold `outReady` = 0 for 4 cycles while offering 10 → `sampleReady` = 0 and the window is frozen at {9,…,2}. Raise `outReady` → 10 is accepted in that same cycle, and `pDataOut[0]` = 10 the next cycle.
- **Flush vs. sample:** assert `flush` together with `sampleValid` (value 55) → `sampleReady` = 0. The next cycle shows taps all 0, `fillCount` 0, `windowValid` 0. Re-offering 55 gives `pDataOut[0]` = 55 with `fillCount` 1.
- **EMIT_PARTIAL = 1:** stream 3, 5 → `windowValid` = 1 after each accept; `pDataOut` = {3,0,…} and then {5,3,0,…}.
